// File: rtl/risc16_pkg.sv
//------------------------------------------------------------------------------
// Module   : risc16_pkg
// Brief    : Shared RiSC-16 constants and types used by the core and its blocks.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package risc16_pkg;

    localparam int WORD_LEN      = 16;
    localparam int REG_ADDR_LEN  = 3;
    localparam int REG_FILE_SIZE = 8;
    localparam int ZERO_REG      = 0;

    typedef logic [WORD_LEN-1:0]     word_t;
    typedef logic [REG_ADDR_LEN-1:0] reg_addr_t;

endpackage : risc16_pkg

`default_nettype wire

// File: rtl/mem_reg.sv
//------------------------------------------------------------------------------
// Module   : mem_reg
// Brief    : RiSC-16 register file, two combinational read ports, one
//            synchronous write port, r0 hard-wired to zero.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_reg
    import risc16_pkg::*;
#(
    parameter int p_WORD_LEN      = WORD_LEN,
    parameter int p_REG_ADDR_LEN  = REG_ADDR_LEN,
    parameter int p_REG_FILE_SIZE = REG_FILE_SIZE
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [p_REG_ADDR_LEN-1:0] i_src1,
    input  logic [p_REG_ADDR_LEN-1:0] i_src2,
    output logic [p_WORD_LEN-1:0]     o_src1_data,
    output logic [p_WORD_LEN-1:0]     o_src2_data,
    input  logic [p_REG_ADDR_LEN-1:0] i_tgt,
    input  logic [p_WORD_LEN-1:0]     i_tgt_data,
    input  logic                      i_wr_en
);

    localparam int c_DEPTH = 2 ** p_REG_ADDR_LEN;

    generate
        if ((p_REG_FILE_SIZE > c_DEPTH) || (p_REG_FILE_SIZE < 2)) begin : g_bad_size
            $error("mem_reg: p_REG_FILE_SIZE must be in [2, 2**p_REG_ADDR_LEN]");
        end
    endgenerate

    // Power-up contents are zero because the core does not drive reset here yet.
    logic [p_WORD_LEN-1:0] mem_q [c_DEPTH] = '{default: '0};

    logic w_wr_hit;
    logic w_src1_ok;
    logic w_src2_ok;

    assign w_wr_hit  = i_wr_en && (32'(i_tgt) != ZERO_REG)
                                && (32'(i_tgt) < p_REG_FILE_SIZE);
    assign w_src1_ok = (32'(i_src1) != ZERO_REG) && (32'(i_src1) < p_REG_FILE_SIZE);
    assign w_src2_ok = (32'(i_src2) != ZERO_REG) && (32'(i_src2) < p_REG_FILE_SIZE);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_wr_hit) begin
            mem_q[i_tgt] <= i_tgt_data;
        end
    end

    // No write bypass: a same-cycle read of the target sees the old value.
    assign o_src1_data = w_src1_ok ? mem_q[i_src1] : '0;
    assign o_src2_data = w_src2_ok ? mem_q[i_src2] : '0;

endmodule : mem_reg

`default_nettype wire

// File: tb/tb_mem_reg.sv
//------------------------------------------------------------------------------
// Module   : tb_mem_reg
// Brief    : Directed self-checking bench for the RiSC-16 register file.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_reg;

    logic        clk;
    logic        rst_n;
    logic [2:0]  src1;
    logic [2:0]  src2;
    logic [15:0] src1_data;
    logic [15:0] src2_data;
    logic [2:0]  tgt;
    logic [15:0] tgt_data;
    logic        wr_en;

    int n_checks = 0;
    int n_errors = 0;

    mem_reg #(
        .p_WORD_LEN      (16),
        .p_REG_ADDR_LEN  (3),
        .p_REG_FILE_SIZE (8)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_src1      (src1),
        .i_src2      (src2),
        .o_src1_data (src1_data),
        .o_src2_data (src2_data),
        .i_tgt       (tgt),
        .i_tgt_data  (tgt_data),
        .i_wr_en     (wr_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present read addresses, let the combinational paths settle, check both ports.
    task automatic read_both(input string tag, input logic [2:0] a, input logic [15:0] exp);
        src1 = a;
        src2 = a;
        #1;
        check({tag, "_p1"}, src1_data, exp);
        check({tag, "_p2"}, src2_data, exp);
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
        tgt      = a;
        tgt_data = d;
        wr_en    = 1'b1;
        @(posedge clk);
        #1;
        wr_en    = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b1;
        src1     = '0;
        src2     = '0;
        tgt      = '0;
        tgt_data = '0;
        wr_en    = 1'b0;
        #2;

        // Power-up contents
        for (int k = 0; k < 8; k++) read_both($sformatf("pwrup_r%0d", k), 3'(k), 16'h0000);

        // Reset clear, including reset overriding a concurrent write
        @(posedge clk); #1;
        write_reg(3'd3, 16'hBEEF);
        read_both("pre_rst_r3", 3'd3, 16'hBEEF);
        rst_n    = 1'b0;
        tgt      = 3'd5;
        tgt_data = 16'h1234;
        wr_en    = 1'b1;
        read_both("rst_sync_r3", 3'd3, 16'hBEEF);
        @(posedge clk); #1;
        wr_en    = 1'b0;
        for (int k = 0; k < 8; k++) read_both($sformatf("rst_r%0d", k), 3'(k), 16'h0000);

        // First edge after reset release performs a normal write
        tgt      = 3'd1;
        tgt_data = 16'hA5A5;
        wr_en    = 1'b1;
        rst_n    = 1'b1;
        @(posedge clk); #1;
        wr_en    = 1'b0;
        read_both("rel_wr_r1", 3'd1, 16'hA5A5);

        // Write/read all
        for (int k = 1; k < 8; k++) write_reg(3'(k), 16'(16'h1111 * k));
        for (int k = 0; k < 8; k++) read_both($sformatf("all_r%0d", k), 3'(k), 16'(16'h1111 * k));

        // Independent ports on different registers
        src1 = 3'd3;
        src2 = 3'd7;
        #1;
        check("indep_p1_r3", src1_data, 16'h3333);
        check("indep_p2_r7", src2_data, 16'h7777);

        // r0 immutability
        write_reg(3'd0, 16'hFFFF);
        read_both("r0_wr", 3'd0, 16'h0000);

        // Write enable gating
        write_reg(3'd4, 16'h00AA);
        tgt      = 3'd4;
        tgt_data = 16'h5555;
        wr_en    = 1'b0;
        @(posedge clk); #1;
        read_both("wen_r4", 3'd4, 16'h00AA);

        // Read during write: old value before the edge, new value after
        write_reg(3'd2, 16'h0007);
        src1     = 3'd2;
        src2     = 3'd2;
        tgt      = 3'd2;
        tgt_data = 16'h0008;
        wr_en    = 1'b1;
        #1;
        check("rdw_pre_p1", src1_data, 16'h0007);
        check("rdw_pre_p2", src2_data, 16'h0007);
        @(posedge clk); #1;
        wr_en    = 1'b0;
        check("rdw_post_p1", src1_data, 16'h0008);
        check("rdw_post_p2", src2_data, 16'h0008);

        // Back-to-back writes to r6
        src2     = 3'd6;
        tgt      = 3'd6;
        tgt_data = 16'h0001;
        wr_en    = 1'b1;
        @(posedge clk); #1;
        check("b2b_e1", src2_data, 16'h0001);
        tgt_data = 16'hFFFF;
        @(posedge clk); #1;
        wr_en    = 1'b0;
        check("b2b_e2", src2_data, 16'hFFFF);

        // Neighbouring registers unaffected by the sequence above
        read_both("keep_r5", 3'd5, 16'h5555);
        read_both("keep_r4", 3'd4, 16'h00AA);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mem_reg

`default_nettype wire
